genie_merge_rr: RTL and testbench
=================================

GENIE_MERGE_RR -- requirements
Module: genie_merge_rr

Interface
REQ-001 Parameter NI, default 2: number of input ports, legal range 2..16.
REQ-002 Parameter WIDTH, default 1: flit data width in bits.
REQ-003 Parameter SELW, default $clog2(NI): width of the grant index.
REQ-004 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 i_reset  input  1  reset, asynchronous and active-high.
REQ-006 i_data  input  NI*WIDTH  input flits; port k occupies bits [k*WIDTH +: WIDTH].
REQ-007 i_valid  input  NI  per-port flit valid.
REQ-008 i_eop  input  NI  per-port end-of-packet marker, qualified by i_valid.
REQ-009 o_ready  output  NI  per-port ready, asserted only for the granted port.
REQ-010 o_data  output  WIDTH  merged flit.
REQ-011 o_valid  output  1  merged flit valid.
REQ-012 o_eop  output  1  merged end-of-packet.
REQ-013 o_sel  output  SELW  index of the port currently driving o_data.
REQ-014 i_ready  input  1  downstream ready (a genie_pipe_stage i_ready/o_ready pair).

Function
REQ-015 Transfer on a port SHALL occur when its valid and ready are both high on a rising edge.
REQ-016 FSM SHALL have two states: IDLE (no port owned) and LOCKED (one port owns the output).
REQ-017 In IDLE, the grant SHALL go to the first port with i_valid high, searching upward from rr_ptr and wrapping NI-1 -> 0.
REQ-018 In IDLE with no valid input: o_valid=0, o_ready=0, state and rr_ptr unchanged.
REQ-019 In IDLE, a granted flit SHALL appear on o_data/o_eop/o_sel in the same cycle (zero latency, macro undefined).
REQ-020 IDLE -> LOCKED when a grant is made and the flit is either not transferred or transferred with eop=0; lock_idx <= grant.
REQ-021 IDLE, grant transferred with eop=1: stay IDLE, rr_ptr <= grant+1 (mod NI).
REQ-022 In LOCKED, only port lock_idx SHALL be connected; other ports' o_ready=0 regardless of their valid.
REQ-023 LOCKED -> IDLE on a transfer with eop=1; rr_ptr <= lock_idx+1 (mod NI).
REQ-024 Grant SHALL never change while o_valid=1 and i_ready=0 (output stability).
REQ-025 o_ready[granted] SHALL equal i_ready (macro undefined); no combinational path from i_valid to any o_ready except through grant selection.
REQ-026 Locked port dropping i_valid mid-packet SHALL leave the lock held and o_valid=0 until it resumes.
REQ-027 rr_ptr increment SHALL wrap modulo NI, including non-power-of-two NI.

Reset
REQ-028 On i_reset: state=IDLE, rr_ptr=0, lock_idx=0, o_valid=0, o_ready=all-0, output register (if present) empty.
REQ-029 Reset mid-packet SHALL discard the lock; the first post-reset grant follows REQ-017 from port 0.
REQ-030 o_data/o_eop/o_sel SHALL be don't-care while o_valid=0.

Configuration
REQ-031 Macro GENIE_MERGE_OUTREG_EN: when defined, o_valid/o_data/o_eop/o_sel SHALL come from a one-entry output register.
REQ-032 With macro: latency 1 cycle; register loads when empty or i_ready=1; granted o_ready = (!reg_valid || i_ready); full throughput on continuous i_ready.
REQ-033 Without macro: pure combinational datapath per REQ-019/REQ-025; FSM behaviour identical at the input side.

Structure
REQ-034 Package genie_merge_pkg SHALL hold the FSM state enum (IDLE, LOCKED) and the NI upper-bound constant (16).
REQ-035 Sub-module genie_rr_arb SHALL implement the combinational rotating-priority search (req vector, base pointer -> grant index, any_grant).
REQ-036 Datapath mux, FSM and optional output register SHALL reside in genie_merge_rr.

Verification
REQ-037 NI=3, all ports valid single-flit eop=1, i_ready=1 -> grants 0,1,2,0 on consecutive cycles.
REQ-038 Port 1 sends 4-flit packet (eop on 4th), port 0 valid throughout -> o_sel=1 for 4 transfers, then o_sel=0.
REQ-039 Granted flit with i_ready=0 for 3 cycles, port 0 becomes valid meanwhile -> o_data/o_sel stable, no switch.
REQ-040 Locked port 2 drops valid 2 cycles mid-packet, port 0 valid -> o_valid=0 for 2 cycles, lock retained.
REQ-041 Assert i_reset during LOCKED on port 1 -> o_valid=0 immediately; next grant from port 0 search.
REQ-042 GENIE_MERGE_OUTREG_EN defined, continuous traffic, i_ready=1 -> first o_valid 1 cycle after input, then one flit per cycle.

Source files
------------

// File: rtl/genie_merge_pkg.sv
// genie_merge_pkg
// Shared definitions for the round-robin packet merge.
//   state_t  : merge FSM state (IDLE = no port owns the output,
//              LOCKED = one port owns the output until its end-of-packet)
//   NI_MAX   : largest supported number of input ports
//   wrap_inc : increment an index modulo n (n need not be a power of two)
package genie_merge_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int NI_MAX = 16;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/genie_rr_arb.sv
// genie_rr_arb
// Combinational rotating-priority search: picks the first asserted request
// at or above 'base', wrapping from NI-1 back to 0.
// Ports:
//   req       in  NI    request vector
//   base      in  SELW  index with highest priority
//   grant     out SELW  index of the winning request (0 when none)
//   any_grant out 1     at least one request is asserted
module genie_rr_arb #(
  parameter int NI   = 2,
  parameter int SELW = $clog2(NI)
) (
  input  logic [NI-1:0]   req,
  input  logic [SELW-1:0] base,
  output logic [SELW-1:0] grant,
  output logic            any_grant
);

  // Walk the offsets from the far end back toward base so that the last
  // hit written, i.e. the smallest offset from base, wins.
  always_comb begin
    logic [SELW-1:0] idx;
    grant     = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = NI - 1; i >= 0; i--) begin
      idx = SELW'((int'(base) + i) % NI);
      if (req[idx]) begin
        grant     = idx;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/genie_merge_rr.sv
// genie_merge_rr
// Merges NI valid/ready packet streams onto one output. Ports compete in
// round-robin order; the winner keeps the output until its end-of-packet
// flit has been transferred, so packets are never interleaved.
// Ports:
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_data  [NI*WIDTH]   input flits, port k at [k*WIDTH +: WIDTH]
//   i_valid, i_eop [NI]  per-port valid and end-of-packet
//   o_ready [NI]         per-port ready, only the granted port can see it
//   o_data, o_valid,
//   o_eop, o_sel         merged flit, its valid, eop and source index
//   i_ready              downstream ready
// Build option: define GENIE_MERGE_OUTREG_EN to drive the merged outputs
// from a one-entry output register (one cycle latency, full throughput).
// Without it the datapath is purely combinational.
module genie_merge_rr
  import genie_merge_pkg::*;
#(
  parameter int NI    = 2,
  parameter int WIDTH = 1,
  parameter int SELW  = $clog2(NI)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [NI*WIDTH-1:0] i_data,
  input  logic [NI-1:0]       i_valid,
  input  logic [NI-1:0]       i_eop,
  output logic [NI-1:0]       o_ready,
  output logic [WIDTH-1:0]    o_data,
  output logic                o_valid,
  output logic                o_eop,
  output logic [SELW-1:0]     o_sel,
  input  logic                i_ready
);

  state_t          state, state_next;
  logic [SELW-1:0] rr_ptr, rr_next;
  logic [SELW-1:0] lock_idx, lock_next;
  logic [SELW-1:0] arb_grant;
  logic            arb_any;
  logic [SELW-1:0] sel;
  logic            granted;
  logic            active;
  logic            in_ready;
  logic            take;
  logic [WIDTH-1:0] sel_data;
  logic            sel_eop;
  logic            sel_valid;

  genie_rr_arb #(
    .NI   (NI),
    .SELW (SELW)
  ) u_arb (
    .req       (i_valid),
    .base      (rr_ptr),
    .grant     (arb_grant),
    .any_grant (arb_any)
  );

  // Source selection: a locked port stays connected even while it is idle,
  // which keeps the lock through gaps inside a packet.
  always_comb begin
    sel       = (state == LOCKED) ? lock_idx : arb_grant;
    granted   = (state == LOCKED) || arb_any;
    sel_data  = '0;
    sel_eop   = 1'b0;
    sel_valid = 1'b0;
    for (int k = 0; k < NI; k++) begin
      if (SELW'(k) == sel) begin
        sel_data  = i_data[k*WIDTH +: WIDTH];
        sel_eop   = i_eop[k];
        sel_valid = i_valid[k];
      end
    end
    active = granted && sel_valid;
  end

`ifdef GENIE_MERGE_OUTREG_EN
  logic             reg_valid;
  logic [WIDTH-1:0] reg_data;
  logic             reg_eop;
  logic [SELW-1:0]  reg_sel;

  assign in_ready = !reg_valid || i_ready;

  // One-entry output register; it refills in the same cycle it drains.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      reg_valid <= 1'b0;
      reg_data  <= '0;
      reg_eop   <= 1'b0;
      reg_sel   <= '0;
    end else if (in_ready) begin
      reg_valid <= active;
      reg_data  <= sel_data;
      reg_eop   <= sel_eop;
      reg_sel   <= sel;
    end
  end

  assign o_valid = reg_valid;
  assign o_data  = reg_data;
  assign o_eop   = reg_eop;
  assign o_sel   = reg_sel;
`else
  assign in_ready = i_ready;

  // Outputs are forced idle during reset so a held reset shows nothing.
  assign o_valid = active && !i_reset;
  assign o_data  = sel_data;
  assign o_eop   = sel_eop;
  assign o_sel   = sel;
`endif

  // Ready depends on valid only through the grant selection.
  always_comb begin
    o_ready = '0;
    for (int k = 0; k < NI; k++) begin
      o_ready[k] = granted && in_ready && !i_reset && (SELW'(k) == sel);
    end
  end

  assign take = active && in_ready && !i_reset;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_next;
      lock_idx <= lock_next;
    end
  end

  // A grant that does not finish its packet this cycle becomes a lock,
  // which also freezes the choice while downstream is stalled.
  always_comb begin
    state_next = state;
    rr_next    = rr_ptr;
    lock_next  = lock_idx;
    case (state)
      IDLE: begin
        if (arb_any) begin
          if (take && sel_eop) begin
            rr_next = SELW'(wrap_inc(int'(arb_grant), NI));
          end else begin
            state_next = LOCKED;
            lock_next  = arb_grant;
          end
        end
      end
      LOCKED: begin
        if (take && sel_eop) begin
          state_next = IDLE;
          rr_next    = SELW'(wrap_inc(int'(lock_idx), NI));
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_genie_merge_rr.sv
// tb_genie_merge_rr
// Self-checking bench for genie_merge_rr (NI=3, WIDTH=8, default build):
// a vector table, hand-written multi-cycle sequences and a randomized run
// compared against an owner/pointer reference model.
module tb_genie_merge_rr;

  localparam int NI    = 3;
  localparam int WIDTH = 8;
  localparam int SELW  = 2;

  logic                clk;
  logic                rst;
  logic [NI*WIDTH-1:0] src_data;
  logic [NI-1:0]       src_valid;
  logic [NI-1:0]       src_eop;
  logic [NI-1:0]       src_ready;
  logic [WIDTH-1:0]    mrg_data;
  logic                mrg_valid;
  logic                mrg_eop;
  logic [SELW-1:0]     mrg_sel;
  logic                dst_ready;

  int checks;
  int errors;

  localparam logic [NI*WIDTH-1:0] FIXED_DATA = 24'hC2B1A0;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] eop;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_sel;
    logic [2:0] exp_ready;
    logic [7:0] exp_data;
    logic       exp_eop;
  } vec_t;

  vec_t vecs[10];

  genie_merge_rr #(
    .NI    (NI),
    .WIDTH (WIDTH),
    .SELW  (SELW)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_data  (src_data),
    .i_valid (src_valid),
    .i_eop   (src_eop),
    .o_ready (src_ready),
    .o_data  (mrg_data),
    .o_valid (mrg_valid),
    .o_eop   (mrg_eop),
    .o_sel   (mrg_sel),
    .i_ready (dst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge and are sampled 1 ns later.
  task automatic applyStimulus(input logic [2:0] v, input logic [2:0] e,
                               input logic [NI*WIDTH-1:0] d, input logic r);
    @(negedge clk);
    src_valid = v;
    src_eop   = e;
    src_data  = d;
    dst_ready = r;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic ev, input logic [1:0] es,
                             input logic [2:0] er, input logic [7:0] ed, input logic ee);
    logic ok;
    ok = (mrg_valid === ev) && (src_ready === er);
    if (ev) ok = ok && (mrg_sel === es) && (mrg_data === ed) && (mrg_eop === ee);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%b ready=%b sel=%0d data=%h eop=%b, want valid=%b ready=%b sel=%0d data=%h eop=%b",
               name, mrg_valid, src_ready, mrg_sel, mrg_data, mrg_eop, ev, er, es, ed, ee);
    end
  endtask

  // Reference model: 'owner' is the port holding the output (-1 when free),
  // 'ptr' is where the next free search starts.
  int owner;
  int ptr;

  task automatic modelCycle(input string name);
    int         s;
    logic       found;
    logic       ev;
    logic [2:0] er;
    s = 0;
    found = 1'b0;
    if (owner < 0) begin
      for (int k = 0; k < NI; k++) begin
        int p;
        p = (ptr + k) % NI;
        if (!found && src_valid[p]) begin
          found = 1'b1;
          s = p;
        end
      end
      ev = found;
    end else begin
      s = owner;
      ev = src_valid[owner];
    end
    er = ((owner >= 0 || found) && dst_ready) ? (3'b001 << s) : 3'b000;
    checkOutput(name, ev, 2'(s), er, src_data[s*WIDTH +: WIDTH], src_eop[s]);
    if (owner >= 0 || found) begin
      if (ev && dst_ready && src_eop[s]) begin
        owner = -1;
        ptr = (s + 1) % NI;
      end else begin
        owner = s;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Row order: idle, single-flit round robin, 4-flit packet on port 1.
    vecs[0] = '{3'b000, 3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 8'h00, 1'b0};
    vecs[1] = '{3'b111, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 8'hA0, 1'b1};
    vecs[2] = '{3'b111, 3'b111, 1'b1, 1'b1, 2'd1, 3'b010, 8'hB1, 1'b1};
    vecs[3] = '{3'b111, 3'b111, 1'b1, 1'b1, 2'd2, 3'b100, 8'hC2, 1'b1};
    vecs[4] = '{3'b111, 3'b111, 1'b1, 1'b1, 2'd0, 3'b001, 8'hA0, 1'b1};
    vecs[5] = '{3'b011, 3'b000, 1'b1, 1'b1, 2'd1, 3'b010, 8'hB1, 1'b0};
    vecs[6] = '{3'b011, 3'b000, 1'b1, 1'b1, 2'd1, 3'b010, 8'hB1, 1'b0};
    vecs[7] = '{3'b011, 3'b000, 1'b1, 1'b1, 2'd1, 3'b010, 8'hB1, 1'b0};
    vecs[8] = '{3'b011, 3'b010, 1'b1, 1'b1, 2'd1, 3'b010, 8'hB1, 1'b1};
    vecs[9] = '{3'b001, 3'b001, 1'b1, 1'b1, 2'd0, 3'b001, 8'hA0, 1'b1};

    // Reset held with traffic present: outputs must stay quiet.
    rst       = 1'b1;
    src_valid = 3'b111;
    src_eop   = 3'b111;
    src_data  = FIXED_DATA;
    dst_ready = 1'b1;
    #2;
    checkOutput("reset_state", 1'b0, 2'd0, 3'b000, 8'h00, 1'b0);
    src_valid = 3'b000;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].eop, FIXED_DATA, vecs[i].ready);
      checkOutput($sformatf("table_%0d", i), vecs[i].exp_valid, vecs[i].exp_sel,
                  vecs[i].exp_ready, vecs[i].exp_data, vecs[i].exp_eop);
    end

    // Stalled grant on port 1 must not move to port 0.
    applyStimulus(3'b010, 3'b010, FIXED_DATA, 1'b0);
    checkOutput("stall_0", 1'b1, 2'd1, 3'b000, 8'hB1, 1'b1);
    applyStimulus(3'b011, 3'b010, FIXED_DATA, 1'b0);
    checkOutput("stall_1", 1'b1, 2'd1, 3'b000, 8'hB1, 1'b1);
    applyStimulus(3'b011, 3'b010, FIXED_DATA, 1'b0);
    checkOutput("stall_2", 1'b1, 2'd1, 3'b000, 8'hB1, 1'b1);
    applyStimulus(3'b011, 3'b010, FIXED_DATA, 1'b1);
    checkOutput("stall_release", 1'b1, 2'd1, 3'b010, 8'hB1, 1'b1);
    applyStimulus(3'b001, 3'b001, FIXED_DATA, 1'b1);
    checkOutput("stall_next", 1'b1, 2'd0, 3'b001, 8'hA0, 1'b1);

    // Port 2 locks, goes quiet for two cycles, then finishes.
    applyStimulus(3'b101, 3'b000, FIXED_DATA, 1'b1);
    checkOutput("gap_lock", 1'b1, 2'd2, 3'b100, 8'hC2, 1'b0);
    applyStimulus(3'b001, 3'b000, FIXED_DATA, 1'b1);
    checkOutput("gap_0", 1'b0, 2'd0, 3'b100, 8'h00, 1'b0);
    applyStimulus(3'b001, 3'b000, FIXED_DATA, 1'b1);
    checkOutput("gap_1", 1'b0, 2'd0, 3'b100, 8'h00, 1'b0);
    applyStimulus(3'b101, 3'b100, FIXED_DATA, 1'b1);
    checkOutput("gap_resume", 1'b1, 2'd2, 3'b100, 8'hC2, 1'b1);
    applyStimulus(3'b001, 3'b001, FIXED_DATA, 1'b1);
    checkOutput("gap_after", 1'b1, 2'd0, 3'b001, 8'hA0, 1'b1);

    // Reset while port 1 holds a lock; search restarts at port 0.
    applyStimulus(3'b011, 3'b000, FIXED_DATA, 1'b1);
    checkOutput("rst_lock", 1'b1, 2'd1, 3'b010, 8'hB1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_during", 1'b0, 2'd0, 3'b000, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_after", 1'b1, 2'd0, 3'b001, 8'hA0, 1'b0);

    // Randomized traffic from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    src_valid = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    owner = -1;
    ptr = 0;
    for (int c = 0; c < 400; c++) begin
      logic [2:0] v;
      logic [2:0] e;
      v = 3'($urandom);
      for (int k = 0; k < NI; k++) e[k] = ($urandom_range(2) == 0);
      applyStimulus(v, e, 24'($urandom), ($urandom_range(3) != 0));
      modelCycle($sformatf("rand_%0d", c));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
